// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-requester bus arbiter.
package bus_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Pointer value that gives requester 0 top priority after reset.
  localparam logic [SEL_W-1:0] RST_PTR = 2'd3;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bus_arb_4_1_rr_pick4.sv
// Combinational round-robin picker: returns the first set bit of the eligible
// mask, scanning from the index just after the last winner and wrapping.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig_mask,
  input  logic [SEL_W-1:0]   last_ptr,
  output logic               any_valid,
  output logic [SEL_W-1:0]   winner
);

  // Scan last+1 .. last+4 (mod 4); the first eligible index wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = last_ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_valid && elig_mask[last_ptr + SEL_W'(i)]) begin
        any_valid = 1'b1;
        winner    = last_ptr + SEL_W'(i);
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/bus_arb_4_1.sv
// Round-robin 4:1 bus arbiter with a registered valid/ready output stage.
// Each capture of a requester's word returns a one-cycle ack to it.
// Optional per-requester saturating grant counters: BUS_ARB_GRANT_CNT_EN.
module bus_arb_4_1
  import bus_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*W-1:0]     i_data,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_valid,
  output logic [W-1:0]             o_data,
  input  logic                     i_ready
`ifdef BUS_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] o_grant_cnt
`endif
);

  state_t             state_r;
  logic [SEL_W-1:0]   last_r;
  logic [SEL_W-1:0]   sel_r;
  logic [W-1:0]       data_r;
  logic [NUM_REQ-1:0] ack_r;

  logic [NUM_REQ-1:0] elig_s;
  logic               any_s;
  logic [SEL_W-1:0]   winner_s;
  logic [W-1:0]       mux_s;
  logic               capture_s;

  // A requester is masked in its own ack cycle so a still-high stale request
  // is never granted twice.
  assign elig_s = i_req & ~ack_r;

  rr_pick4 u_pick (
    .elig_mask (elig_s),
    .last_ptr  (last_r),
    .any_valid (any_s),
    .winner    (winner_s)
  );

  // 4:1 bus mux driven by the picker's winner index.
  always_comb begin
    mux_s = {W{1'b0}};
    case (winner_s)
      2'd0:    mux_s = i_data[0*W +: W];
      2'd1:    mux_s = i_data[1*W +: W];
      2'd2:    mux_s = i_data[2*W +: W];
      2'd3:    mux_s = i_data[3*W +: W];
      default: mux_s = {W{1'b0}};
    endcase
  end

  // The output register can take a new word when empty or being drained.
  assign capture_s = ((state_r == ST_IDLE) || i_ready) && any_s;

  // Output-stage FSM: capture winner, drain on ready, hold on back-pressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      last_r  <= RST_PTR;
      sel_r   <= {SEL_W{1'b0}};
      data_r  <= {W{1'b0}};
      ack_r   <= {NUM_REQ{1'b0}};
    end else begin
      ack_r <= {NUM_REQ{1'b0}};
      if (capture_s) begin
        state_r <= ST_FULL;
        data_r  <= mux_s;
        sel_r   <= winner_s;
        last_r  <= winner_s;
        ack_r   <= onehot4(winner_s);
      end else if ((state_r == ST_FULL) && i_ready) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign o_valid = (state_r == ST_FULL);
  assign o_data  = data_r;
  assign o_sel   = sel_r;
  assign o_ack   = ack_r;

`ifdef BUS_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_r [NUM_REQ];

  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else if (capture_s && (cnt_r[winner_s] != {CNT_W{1'b1}})) begin
      cnt_r[winner_s] <= cnt_r[winner_s] + CNT_W'(1);
    end else begin
      cnt_r[winner_s] <= cnt_r[winner_s];
    end
  end

  // Pack the counters onto the output bus, counter k at bits [k*8 +: 8].
  always_comb begin
    o_grant_cnt = {(NUM_REQ*CNT_W){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      o_grant_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
    end
  end
`endif

endmodule
